// File: rtl/fb_rect_fill.sv
// Rectangle-fill engine: clips a solid-color rectangle to the screen and
// streams one frame-buffer word write per granted cycle in raster order.
module fb_rect_fill #(
    parameter int unsigned H_RES   = 160,
    parameter int unsigned V_RES   = 120,
    parameter int unsigned FB_BASE = 0,
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DATA_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [7:0]        cmd_x,
    input  logic [7:0]        cmd_y,
    input  logic [7:0]        cmd_w,
    input  logic [7:0]        cmd_h,
    input  logic [7:0]        cmd_color,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_grant,
    output logic              busy,
    output logic              done
);

    // One extra bit over the 8-bit command fields so clip math never wraps.
    localparam int unsigned DIM_W = 9;
    localparam logic [DIM_W-1:0]  H_RES9   = DIM_W'(H_RES);
    localparam logic [DIM_W-1:0]  V_RES9   = DIM_W'(V_RES);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(H_RES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_WRITE,
        S_DONE
    } state_e;

    state_e              state_q;
    logic [7:0]          x_q, y_q, w_q, h_q, color_q;
    logic [DIM_W-1:0]    ew_q, eh_q, col_q, row_q;
    logic [ADDR_W-1:0]   row_base_q;
    logic                cmd_ready_q, mem_we_q, busy_q, done_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;

    logic [DIM_W-1:0]    x9, y9, w9, h9, rem_w, rem_h;
    logic [DIM_W-1:0]    ew_d, eh_d;
    logic [ADDR_W-1:0]   base_d;
    logic                empty_d, last_col, last_row;

    // Clip extents, first-row address and raster-position flags.
    always_comb begin
        x9       = {1'b0, x_q};
        y9       = {1'b0, y_q};
        w9       = {1'b0, w_q};
        h9       = {1'b0, h_q};
        empty_d  = (w_q == 8'd0) || (h_q == 8'd0) || (x9 >= H_RES9) || (y9 >= V_RES9);
        rem_w    = H_RES9 - x9;
        rem_h    = V_RES9 - y9;
        ew_d     = (w9 < rem_w) ? w9 : rem_w;
        eh_d     = (h9 < rem_h) ? h9 : rem_h;
        base_d   = ADDR_W'(FB_BASE + (32'(y_q) * H_RES) + 32'(x_q));
        last_col = (col_q == ew_q - 9'd1);
        last_row = (row_q == eh_q - 9'd1);
    end

    // Command FSM with registered handshake and memory-write outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            w_q         <= '0;
            h_q         <= '0;
            color_q     <= '0;
            ew_q        <= '0;
            eh_q        <= '0;
            col_q       <= '0;
            row_q       <= '0;
            row_base_q  <= '0;
            cmd_ready_q <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (cmd_valid && cmd_ready_q) begin
                        x_q         <= cmd_x;
                        y_q         <= cmd_y;
                        w_q         <= cmd_w;
                        h_q         <= cmd_h;
                        color_q     <= cmd_color;
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (empty_d) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        ew_q        <= ew_d;
                        eh_q        <= eh_d;
                        col_q       <= '0;
                        row_q       <= '0;
                        row_base_q  <= base_d;
                        mem_addr_q  <= base_d;
                        mem_wdata_q <= DATA_W'(color_q);
                        mem_we_q    <= 1'b1;
                        state_q     <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    // Without a grant every output holds and nothing advances.
                    if (mem_grant) begin
                        if (!last_col) begin
                            col_q      <= col_q + 9'd1;
                            mem_addr_q <= mem_addr_q + ADDR_W'(1);
                        end else if (!last_row) begin
                            col_q      <= '0;
                            row_q      <= row_q + 9'd1;
                            row_base_q <= row_base_q + ROW_STEP;
                            mem_addr_q <= row_base_q + ROW_STEP;
                        end else begin
                            mem_we_q <= 1'b0;
                            done_q   <= 1'b1;
                            state_q  <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    done_q      <= 1'b0;
                    busy_q      <= 1'b0;
                    cmd_ready_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_fb_rect_fill.sv
// Bench for fb_rect_fill: command table plus hand-written corner sequences,
// expected writes queued at command issue and popped on each granted write.
module tb_fb_rect_fill;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_x, cmd_y, cmd_w, cmd_h, cmd_color;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_grant;
    logic        busy;
    logic        done;

    fb_rect_fill dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_x     (cmd_x),
        .cmd_y     (cmd_y),
        .cmd_w     (cmd_w),
        .cmd_h     (cmd_h),
        .cmd_color (cmd_color),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_grant (mem_grant),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] x, y, w, h, c;
    } cmd_t;

    typedef struct {
        cmd_t c;
        int   mode;      // 0: grant always, 1: grant on odd cycles, 2: random
        int   exp_wr;
        int   exp_done;  // cycle of done after accept edge, -1 = not fixed
    } vec_t;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
    } wr_t;

    wr_t  exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   first_we, last_wr, done_cyc, nwr, nwe, rdy_hi, waited;
    vec_t vt[11];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int x, input int y, input int w, input int h,
                                input int c, input int mode, input int wr, input int dn);
        vec_t v;
        v.c.x = 8'(x); v.c.y = 8'(y); v.c.w = 8'(w); v.c.h = 8'(h); v.c.c = 8'(c);
        v.mode = mode; v.exp_wr = wr; v.exp_done = dn;
        return v;
    endfunction

    // Reference model: clip, then queue every pixel write in raster order.
    task automatic push_model(input cmd_t c);
        int ew, eh;
        wr_t e;
        if (c.w == 0 || c.h == 0 || int'(c.x) >= 160 || int'(c.y) >= 120) return;
        ew = (int'(c.w) < 160 - int'(c.x)) ? int'(c.w) : 160 - int'(c.x);
        eh = (int'(c.h) < 120 - int'(c.y)) ? int'(c.h) : 120 - int'(c.y);
        for (int r = 0; r < eh; r++) begin
            for (int k = 0; k < ew; k++) begin
                e.addr = 16'((int'(c.y) + r) * 160 + int'(c.x) + k);
                e.data = {8'h00, c.c};
                exp_q.push_back(e);
            end
        end
    endtask

    // Called just after a negedge; returns with the accept at the next posedge.
    task automatic send(input cmd_t c, output int wt);
        cmd_x = c.x; cmd_y = c.y; cmd_w = c.w; cmd_h = c.h; cmd_color = c.c;
        cmd_valid = 1'b1;
        wt = 0;
        while (!cmd_ready && wt < 100) begin
            @(negedge clk);
            wt++;
        end
        if (!cmd_ready) begin
            n_cmp++; n_err++;
            $display("FAIL accept_timeout: cmd_ready still 0 after %0d cycles", wt);
        end
        push_model(c);
    endtask

    // Follows one command cycle by cycle from the accept edge, driving grant.
    task automatic run_cmd(input int mode, input int abort_at, input bit hold_next,
                           input cmd_t nxt);
        bit          g, stall_pend;
        logic [15:0] s_addr, s_data;
        wr_t         e;
        first_we = -1; last_wr = -1; done_cyc = -1; nwr = 0; nwe = 0; rdy_hi = 0;
        stall_pend = 1'b0; s_addr = '0; s_data = '0;
        for (int cyc = 1; cyc <= 2000; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                if (hold_next) begin
                    cmd_x = nxt.x; cmd_y = nxt.y; cmd_w = nxt.w; cmd_h = nxt.h;
                    cmd_color = nxt.c;
                end else begin
                    cmd_valid = 1'b0;
                end
            end
            case (mode)
                0:       g = 1'b1;
                1:       g = (cyc % 2 == 1);
                default: g = 1'($urandom_range(0, 1));
            endcase
            mem_grant = g;
            if (stall_pend) begin
                check("stall_we", int'(mem_we), 1);
                check("stall_addr", int'(mem_addr), int'(s_addr));
                check("stall_data", int'(mem_wdata), int'(s_data));
                stall_pend = 1'b0;
            end
            if (cmd_ready && done_cyc < 0) rdy_hi++;
            if (mem_we) begin
                nwe++;
                if (first_we < 0) first_we = cyc;
            end
            if (mem_we && g) begin
                nwr++;
                last_wr = cyc;
                if (exp_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_write: addr %0d with empty scoreboard", mem_addr);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", int'(mem_addr), int'(e.addr));
                    check("wr_data", int'(mem_wdata), int'(e.data));
                end
                if (nwr == abort_at) return;
            end else if (mem_we) begin
                stall_pend = 1'b1;
                s_addr = mem_addr;
                s_data = mem_wdata;
            end
            if (done) begin
                done_cyc = cyc;
                break;
            end
        end
        mem_grant = 1'b1;
        if (done_cyc < 0) begin
            n_cmp++; n_err++;
            $display("FAIL done_timeout: no done pulse within budget");
        end else begin
            @(negedge clk);
            check("done_one_cycle", int'(done), 0);
            check("ready_after_done", int'(cmd_ready), 1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        cmd_t none, a, b;
        none = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0};

        vt[0]  = mk(2,   3,   4,   2,   8'hA5, 0, 8,  10);
        vt[1]  = mk(2,   3,   4,   2,   8'hA5, 1, 8,  18);
        vt[2]  = mk(158, 118, 5,   5,   8'h3C, 0, 4,  6);
        vt[3]  = mk(0,   0,   0,   5,   8'h11, 0, 0,  2);
        vt[4]  = mk(200, 10,  4,   4,   8'h22, 0, 0,  2);
        vt[5]  = mk(5,   130, 2,   2,   8'h33, 0, 0,  2);
        vt[6]  = mk(0,   0,   1,   1,   8'hFF, 0, 1,  3);
        vt[7]  = mk(150, 0,   20,  1,   8'h44, 0, 10, 12);
        vt[8]  = mk(0,   119, 3,   9,   8'h55, 0, 3,  5);
        vt[9]  = mk(10,  20,  3,   3,   8'h66, 2, 9,  -1);
        vt[10] = mk(159, 119, 255, 255, 8'h77, 0, 1,  3);

        rst_n = 1'b0; cmd_valid = 1'b0; mem_grant = 1'b1;
        cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0; cmd_color = '0;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", int'(cmd_ready), 1);
        check("rst_mem_we", int'(mem_we), 0);
        check("rst_mem_addr", int'(mem_addr), 0);
        check("rst_mem_wdata", int'(mem_wdata), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_no_we_with_grant", int'(mem_we), 0);

        // Table of commands, each run to completion.
        for (int i = 0; i < 11; i++) begin
            send(vt[i].c, waited);
            check("accept_wait", waited, 0);
            run_cmd(vt[i].mode, -1, 1'b0, none);
            check("write_count", nwr, vt[i].exp_wr);
            check("scoreboard_empty", exp_q.size(), 0);
            check("ready_low_while_busy", rdy_hi, 0);
            if (vt[i].exp_wr > 0) begin
                check("first_we_latency", first_we, 2);
                check("done_after_last", done_cyc - last_wr, 1);
            end else begin
                check("zero_we_cycles", nwe, 0);
            end
            if (vt[i].exp_done >= 0) check("done_cycle", done_cyc, vt[i].exp_done);
            else check("done_min_cycle", int'(done_cyc >= 2 + vt[i].exp_wr), 1);
        end

        // Second command held valid during the first: waits, then runs fully.
        a = vt[0].c;
        b = '{8'd50, 8'd60, 8'd3, 8'd2, 8'h5A};
        send(a, waited);
        run_cmd(0, -1, 1'b1, b);
        check("busy_reject_ready", rdy_hi, 0);
        check("busy_first_writes", nwr, 8);
        send(b, waited);
        check("second_accept_first_idle", waited, 0);
        run_cmd(0, -1, 1'b0, none);
        check("second_writes", nwr, 6);
        check("second_done_cycle", done_cyc, 8);
        check("second_scoreboard_empty", exp_q.size(), 0);

        // Reset during a fill abandons it asynchronously.
        send(a, waited);
        run_cmd(0, 3, 1'b0, none);
        check("abort_writes", nwr, 3);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_mem_we", int'(mem_we), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_cmd_ready", int'(cmd_ready), 1);
        check("midrst_done", int'(done), 0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send('{8'd100, 8'd50, 8'd3, 8'd2, 8'h77}, waited);
        run_cmd(0, -1, 1'b0, none);
        check("post_rst_writes", nwr, 6);
        check("post_rst_first_we", first_we, 2);
        check("post_rst_done_cycle", done_cyc, 8);
        check("post_rst_scoreboard_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
